inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning number of instruction entries (power of two, 2..64).
REQ-002 The block SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port rdy  input  1  global enable; low freezes all state.
REQ-005 The block SHALL have port in_valid  input  1  fetcher presents an assembled instruction this cycle.
REQ-006 The block SHALL have port in_inst  input  32  assembled instruction word, byte 0 in [7:0].
REQ-007 The block SHALL have port in_pc  input  32  address of in_inst.
REQ-008 The block SHALL have port full  output  1  queue cannot accept a push; fetcher stalls.
REQ-009 The block SHALL have port out_valid  output  1  head entry available to decoder.
REQ-010 The block SHALL have port out_inst  output  32  head instruction.
REQ-011 The block SHALL have port out_pc  output  32  head PC.
REQ-012 The block SHALL have port out_ready  input  1  decoder consumes head this cycle.
REQ-013 The block SHALL have port flush  input  1  discard all entries (branch redirect).

Function
REQ-014 Storage SHALL be a circular buffer of DEPTH {inst, pc} entries with head and tail pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits.
REQ-015 Push SHALL occur when rdy && in_valid && !full && !flush: entry written at tail, tail+1 modulo DEPTH, count+1.
REQ-016 Pop SHALL occur when rdy && out_valid && out_ready && !flush: head+1 modulo DEPTH, count-1.
REQ-017 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-018 When full, a push attempt SHALL be ignored even if a pop occurs in the same cycle; full deasserts the cycle after the pop.
REQ-019 When empty, a pushed entry SHALL NOT bypass; it appears on out_* one cycle after the push edge (latency 1).
REQ-020 out_valid SHALL equal (count != 0); out_inst/out_pc SHALL be a combinational read of the head entry (show-ahead).
REQ-021 full SHALL equal (count == DEPTH), derived from registered count only.
REQ-022 flush SHALL take priority over push and pop: next edge head=tail=0, count=0; same-cycle push dropped.
REQ-023 Pointer wrap from DEPTH-1 to 0 SHALL be seamless with no bubble.
REQ-024 rdy low SHALL hold pointers, count and storage; flush and push while rdy low SHALL be ignored.
REQ-025 out_inst/out_pc while out_valid is low SHALL be don't-care; the bench SHALL NOT check them.

Reset
REQ-026 On rst high, head, tail and count SHALL clear to 0 immediately; out_valid=0, full=0.
REQ-027 Storage contents SHALL NOT require reset.
REQ-028 Reset asserted mid-operation SHALL discard all entries; first push after deassertion appears at out_* one cycle later.

Configuration
REQ-029 Macro INST_QUEUE_CNT_EN SHALL, when defined, add output port count  output  log2(DEPTH)+1  current occupancy (registered count).
REQ-030 Without INST_QUEUE_CNT_EN the count port SHALL be absent; all other behaviour identical.

Structure
REQ-031 A shared package SHALL hold INST_W=32, ADDR_W=32 and the typedef for the {inst, pc} entry record.
REQ-032 One sub-module SHALL be natural: iq_ram, a DEPTH-entry register array with one write port and one asynchronous read port.

Verification
REQ-033 Reset then push inst 0x00000513 pc 0x0 -> out_valid=1 next cycle, out_inst=0x00000513, out_pc=0x0.
REQ-034 Push 16 entries (pc 0x0..0x3C) with out_ready=0 -> full=1 after 16th push; 17th push dropped; drain yields pc 0x0..0x3C in order.
REQ-035 Full queue, in_valid=1 and out_ready=1 same cycle -> pop of pc 0x0 only, count=15, full=0 next cycle; next push accepted.
REQ-036 Continuous push/pop for 40 cycles, pc incrementing by 4 -> count steady at 1, outputs in order across two pointer wraps.
REQ-037 Queue holding 5 entries, flush=1 with in_valid=1 -> out_valid=0 next cycle, count=0, pushed entry absent.
REQ-038 Queue holding 3 entries, rdy=0 for 4 cycles with in_valid=1, out_ready=1 -> count stays 3, head pc unchanged; rst pulse mid-burst -> out_valid=0 immediately.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// Shared definitions for the instruction queue.
// Holds the instruction and address widths and the {inst, pc} entry record
// stored in each queue slot.
package inst_queue_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 32;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } iq_entry_t;

endpackage

// File: rtl/iq_ram.sv
// Instruction queue storage: DEPTH-entry register array with one synchronous
// write port and one asynchronous (combinational) read port. No reset on the
// contents.
// Ports:
//   i_clk   - clock, writes occur on rising edge
//   i_we    - write enable
//   i_waddr - write slot index
//   i_wdata - entry written
//   i_raddr - read slot index
//   o_rdata - entry at i_raddr (combinational)
module iq_ram
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_waddr,
  input  iq_entry_t                  i_wdata,
  input  logic [$clog2(DEPTH)-1:0]   i_raddr,
  output iq_entry_t                  o_rdata
);

  iq_entry_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between the fetcher and the decoder: a circular buffer of
// DEPTH {inst, pc} entries with show-ahead head output.
// Optional feature: define INST_QUEUE_CNT_EN to expose the occupancy on the
// 'count' output port.
// Ports:
//   clk       - clock, all state updates on rising edge
//   rst       - asynchronous active-high reset
//   rdy       - global enable; low freezes all state
//   in_valid  - fetcher presents an instruction
//   in_inst   - instruction word
//   in_pc     - address of in_inst
//   full      - queue cannot accept a push
//   out_valid - head entry available
//   out_inst  - head instruction
//   out_pc    - head PC
//   out_ready - decoder consumes head this cycle
//   flush     - discard all entries
//   count     - (INST_QUEUE_CNT_EN only) current occupancy
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     in_valid,
  input  logic [INST_W-1:0]        in_inst,
  input  logic [ADDR_W-1:0]        in_pc,
  output logic                     full,
  output logic                     out_valid,
  output logic [INST_W-1:0]        out_inst,
  output logic [ADDR_W-1:0]        out_pc,
  input  logic                     out_ready,
  input  logic                     flush
`ifdef INST_QUEUE_CNT_EN
  ,
  output logic [$clog2(DEPTH):0]   count
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = DEPTH[PtrW:0];

  logic [PtrW-1:0] r_head, r_tail;
  logic [PtrW:0]   r_count;
  logic [PtrW-1:0] w_head_nxt, w_tail_nxt;
  logic [PtrW:0]   w_count_nxt;
  logic            w_push, w_pop;
  iq_entry_t       w_wdata, w_rdata;

  // full and out_valid come only from the registered count, so a pop never
  // frees a slot for a push in the same cycle.
  assign full      = (r_count == FullCnt);
  assign out_valid = (r_count != '0);

  assign w_push = rdy && in_valid && !full && !flush;
  assign w_pop  = rdy && out_valid && out_ready && !flush;

  always_comb begin
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    if (rdy) begin
      if (flush) begin
        w_head_nxt  = '0;
        w_tail_nxt  = '0;
        w_count_nxt = '0;
      end else begin
        // Power-of-two depth: pointer overflow is the modulo wrap.
        if (w_push) w_tail_nxt = r_tail + PtrW'(1);
        if (w_pop)  w_head_nxt = r_head + PtrW'(1);
        unique case ({w_push, w_pop})
          2'b10:   w_count_nxt = r_count + (PtrW + 1)'(1);
          2'b01:   w_count_nxt = r_count - (PtrW + 1)'(1);
          default: w_count_nxt = r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign w_wdata = '{inst: in_inst, pc: in_pc};

  iq_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_push),
    .i_waddr (r_tail),
    .i_wdata (w_wdata),
    .i_raddr (r_head),
    .o_rdata (w_rdata)
  );

  assign out_inst = w_rdata.inst;
  assign out_pc   = w_rdata.pc;

`ifdef INST_QUEUE_CNT_EN
  assign count = r_count;
`endif

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        full;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
`ifdef INST_QUEUE_CNT_EN
  logic [$clog2(DEPTH):0] count;
`endif

  always #5 clk = ~clk;

  inst_queue #(
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .in_valid  (in_valid),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .full      (full),
    .out_valid (out_valid),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .out_ready (out_ready),
    .flush     (flush)
`ifdef INST_QUEUE_CNT_EN
    ,
    .count     (count)
`endif
  );

  iq_entry_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          rdy;
    bit          iv;
    logic [31:0] inst;
    logic [31:0] pc;
    bit          ordy;
    bit          fl;
    bit          ev;
    bit          ef;
  } vec_t;

  vec_t tbl[8];

  function automatic logic [31:0] mk(input logic [31:0] pc);
    return {pc[19:0], 12'h013};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Called at posedge+1. Applies inputs, checks the show-ahead head against the
  // scoreboard before the edge, advances the model, then checks flags after it.
  task automatic drive(input bit r, input bit iv, input logic [31:0] inst,
                       input logic [31:0] pc, input bit ordy, input bit fl);
    bit pop, push;
    rdy       = r;
    in_valid  = iv;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    #1;
    if (sb.size() != 0) begin
      chk("head inst", out_inst, sb[0].inst);
      chk("head pc", out_pc, sb[0].pc);
    end
    if (r) begin
      if (fl) begin
        sb.delete();
      end else begin
        pop  = (sb.size() != 0) && ordy;
        push = iv && (sb.size() != DEPTH);
        if (pop)  void'(sb.pop_front());
        if (push) sb.push_back('{inst: inst, pc: pc});
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, sb.size() != 0);
    chk("full", full, sb.size() == DEPTH);
`ifdef INST_QUEUE_CNT_EN
    chk("count", count, sb.size());
`endif
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) drive(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [31:0] p;

    //             rdy iv  inst          pc     ordy fl  ev  ef
    tbl[0] = '{1'b1, 1'b1, 32'h00000513, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 32'h0,        32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 32'h00100593, 32'h4, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 32'h0,        32'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 32'h00200613, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 32'h00200613, 32'h8, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 32'h00300693, 32'hC, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 32'h0,        32'h0, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset full", full, 1'b0);
    rst = 1'b0;

    // Basic push/pop/rdy/flush vectors.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].rdy, tbl[i].iv, tbl[i].inst, tbl[i].pc, tbl[i].ordy, tbl[i].fl);
      chk($sformatf("vec%0d valid", i), out_valid, tbl[i].ev);
      chk($sformatf("vec%0d full", i), full, tbl[i].ef);
      if (i == 0) begin
        chk("first inst", out_inst, 32'h00000513);
        chk("first pc", out_pc, 32'h0);
      end
    end

    // Fill to full, drop the 17th, pop-on-full, refill, drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      p = 32'(i * 4);
      drive(1'b1, 1'b1, mk(p), p, 1'b0, 1'b0);
    end
    chk("fill full", full, 1'b1);
    drive(1'b1, 1'b1, mk(32'h40), 32'h40, 1'b0, 1'b0);
    chk("17th dropped full", full, 1'b1);
    drive(1'b1, 1'b1, mk(32'h40), 32'h40, 1'b1, 1'b0);
    chk("pop on full clears", full, 1'b0);
    chk("pop on full head", out_pc, 32'h4);
    drive(1'b1, 1'b1, mk(32'h40), 32'h40, 1'b0, 1'b0);
    chk("refill full", full, 1'b1);
    drain();
    chk("drained", out_valid, 1'b0);

    // Streaming push/pop across two pointer wraps.
    p = 32'h100;
    drive(1'b1, 1'b1, mk(p), p, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      p = p + 32'd4;
      drive(1'b1, 1'b1, mk(p), p, 1'b1, 1'b0);
      chk("stream head pc", out_pc, p);
    end
    drain();

    // Flush with a same-cycle push.
    for (int i = 0; i < 5; i++) begin
      p = 32'h200 + 32'(i * 4);
      drive(1'b1, 1'b1, mk(p), p, 1'b0, 1'b0);
    end
    drive(1'b1, 1'b1, mk(32'h300), 32'h300, 1'b0, 1'b1);
    chk("flush empties", out_valid, 1'b0);
    idle();
    chk("flush push absent", out_valid, 1'b0);

    // rdy low freezes state (push, pop and flush ignored).
    for (int i = 0; i < 3; i++) begin
      p = 32'h400 + 32'(i * 4);
      drive(1'b1, 1'b1, mk(p), p, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, mk(32'h500), 32'h500, 1'b1, i == 3);
      chk("frozen head pc", out_pc, 32'h400);
      chk("frozen valid", out_valid, 1'b1);
    end

    // Asynchronous reset mid-burst.
    drive(1'b1, 1'b1, mk(32'h50C), 32'h50C, 1'b1, 1'b0);
    drive(1'b1, 1'b1, mk(32'h510), 32'h510, 1'b1, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("async rst valid", out_valid, 1'b0);
    chk("async rst full", full, 1'b0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 1'b1, mk(32'h600), 32'h600, 1'b0, 1'b0);
    chk("post rst valid", out_valid, 1'b1);
    chk("post rst pc", out_pc, 32'h600);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
